// File: rtl/mhsa_pkg.sv
// Shared definitions for the MHSA accelerator control path.
//   sched_state_t : layer scheduler FSM states
//   LYR_*         : launch-order index of each layer engine
//   MEM_AW        : shared memory bar address width
package mhsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_NEXT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } sched_state_t;

    localparam int LYR_LINEAR  = 0;
    localparam int LYR_QKMM    = 1;
    localparam int LYR_SOFTMAX = 2;
    localparam int LYR_SVMM    = 3;

    localparam int MEM_AW = 32;

endpackage

// File: rtl/mhsa_bar_mux.sv
// Combinational N_LAYER:1 mux for one shared memory bar.
//   grant        : when low, every output is forced to zero
//   sel          : index of the layer that owns the bar
//   lyr_*        : per-layer write enable / address / write data requests
//   write_en, addr, data_in : request forwarded to the memory
module mhsa_bar_mux
    import mhsa_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int N_LAYER = 4,
    parameter int SW      = (N_LAYER > 1) ? $clog2(N_LAYER) : 1
) (
    input  logic              grant,
    input  logic [SW-1:0]     sel,
    input  logic              lyr_write_en [N_LAYER],
    input  logic [MEM_AW-1:0] lyr_addr     [N_LAYER],
    input  logic [WIDTH-1:0]  lyr_data_in  [N_LAYER],
    output logic              write_en,
    output logic [MEM_AW-1:0] addr,
    output logic [WIDTH-1:0]  data_in
);

    // One-hot hit vector; the AND-OR below never selects an index that
    // does not exist, even when N_LAYER is not a power of two.
    logic [N_LAYER-1:0] hit;

    generate
        for (genvar gi = 0; gi < N_LAYER; gi++) begin : g_hit
            assign hit[gi] = grant && (sel == SW'(gi));
        end
    endgenerate

    always_comb begin
        write_en = 1'b0;
        addr     = '0;
        data_in  = '0;
        for (int i = 0; i < N_LAYER; i++) begin
            if (hit[i]) begin
                write_en = write_en | lyr_write_en[i];
                addr     = addr     | lyr_addr[i];
                data_in  = data_in  | lyr_data_in[i];
            end
        end
    end

endmodule

// File: rtl/mhsa_layer_scheduler.sv
// Top-level sequencer of the MHSA accelerator. A single start launches the
// enabled layer engines one at a time in index order, grants the two shared
// memory bars to the running layer only, watches each layer with a timeout
// and counts the cycles of the run.
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : run request / return to IDLE from any state
//   layer_en            : enable mask, latched on an accepted start
//   busy, done, error   : status; done is a one-cycle pulse, error is sticky
//   err_layer           : layer that timed out
//   cycle_cnt           : cycles from accepted start to done (saturating)
//   layer_start/done    : per-layer handshake pulses
//   lyr_*_bar0/1        : per-layer bar requests
//   *_bar0/1            : bar requests to memory; data_out_bar* is read data
module mhsa_layer_scheduler
    import mhsa_pkg::*;
#(
    parameter int          WIDTH   = 64,
    parameter int          N_LAYER = 4,
    parameter logic [31:0] TIMEOUT = 32'd65536
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_LAYER-1:0] layer_en,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_layer,
    output logic [31:0]        cycle_cnt,
    output logic [N_LAYER-1:0] layer_start,
    input  logic [N_LAYER-1:0] layer_done,
    input  logic               lyr_write_en_bar0 [N_LAYER],
    input  logic [MEM_AW-1:0]  lyr_addr_bar0     [N_LAYER],
    input  logic [WIDTH-1:0]   lyr_data_in_bar0  [N_LAYER],
    input  logic               lyr_write_en_bar1 [N_LAYER],
    input  logic [MEM_AW-1:0]  lyr_addr_bar1     [N_LAYER],
    input  logic [WIDTH-1:0]   lyr_data_in_bar1  [N_LAYER],
    output logic               write_en_bar0,
    output logic [MEM_AW-1:0]  addr_bar0,
    output logic [WIDTH-1:0]   data_in_bar0,
    output logic               write_en_bar1,
    output logic [MEM_AW-1:0]  addr_bar1,
    output logic [WIDTH-1:0]   data_in_bar1,
    input  logic [WIDTH-1:0]   data_out_bar0,
    input  logic [WIDTH-1:0]   data_out_bar1
);

    localparam int SW = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;

    sched_state_t       state_q, state_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic [N_LAYER-1:0] mask_q, mask_d;
    logic               error_q, error_d;
    logic [1:0]         err_layer_q, err_layer_d;
    logic [31:0]        cycle_cnt_q, cycle_cnt_d;
    logic [31:0]        wdog_q, wdog_d;

    logic               first_found;
    logic [SW-1:0]      first_idx;
    logic               nxt_found;
    logic [SW-1:0]      nxt_idx;

    // Memory read data is broadcast to the layers outside this block.
    logic unused_data_out;
    assign unused_data_out = ^{data_out_bar0, data_out_bar1};

    // Lowest enabled index of the incoming mask, and lowest enabled index
    // above sel in the latched mask. Scanning downward lets the lowest win.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        nxt_found   = 1'b0;
        nxt_idx     = sel_q;
        for (int i = N_LAYER - 1; i >= 0; i--) begin
            if (layer_en[i]) begin
                first_found = 1'b1;
                first_idx   = SW'(i);
            end
            if (mask_q[i] && (SW'(i) > sel_q)) begin
                nxt_found = 1'b1;
                nxt_idx   = SW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        mask_d      = mask_q;
        error_d     = error_q;
        err_layer_d = err_layer_q;
        cycle_cnt_d = cycle_cnt_q;
        wdog_d      = wdog_q;

        if (state_q != ST_IDLE && state_q != ST_ERR && cycle_cnt_q != 32'hFFFF_FFFF) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end

        // Abort overrides every transition, including a start seen in IDLE.
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mask_d      = layer_en;
                        cycle_cnt_d = '0;
                        error_d     = 1'b0;
                        sel_d       = first_idx;
                        state_d     = first_found ? ST_LAUNCH : ST_DONE;
                    end
                end
                ST_LAUNCH: begin
                    wdog_d  = '0;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    // A done in the final watchdog cycle still counts.
                    if (layer_done[sel_q]) begin
                        state_d = ST_NEXT;
                    end else if (wdog_q == TIMEOUT - 32'd1) begin
                        state_d     = ST_ERR;
                        error_d     = 1'b1;
                        err_layer_d = 2'(sel_q);
                    end else begin
                        wdog_d = wdog_q + 32'd1;
                    end
                end
                ST_NEXT: begin
                    if (nxt_found) begin
                        sel_d   = nxt_idx;
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            mask_q      <= '0;
            error_q     <= 1'b0;
            err_layer_q <= '0;
            cycle_cnt_q <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            mask_q      <= mask_d;
            error_q     <= error_d;
            err_layer_q <= err_layer_d;
            cycle_cnt_q <= cycle_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE) && !abort;
    assign error     = error_q;
    assign err_layer = err_layer_q;
    assign cycle_cnt = cycle_cnt_q;

    generate
        for (genvar gi = 0; gi < N_LAYER; gi++) begin : g_start
            assign layer_start[gi] = (state_q == ST_LAUNCH) && !abort && (sel_q == SW'(gi));
        end
    endgenerate

    mhsa_bar_mux #(.WIDTH(WIDTH), .N_LAYER(N_LAYER), .SW(SW)) u_bar0_mux (
        .grant        (state_q == ST_RUN),
        .sel          (sel_q),
        .lyr_write_en (lyr_write_en_bar0),
        .lyr_addr     (lyr_addr_bar0),
        .lyr_data_in  (lyr_data_in_bar0),
        .write_en     (write_en_bar0),
        .addr         (addr_bar0),
        .data_in      (data_in_bar0)
    );

    mhsa_bar_mux #(.WIDTH(WIDTH), .N_LAYER(N_LAYER), .SW(SW)) u_bar1_mux (
        .grant        (state_q == ST_RUN),
        .sel          (sel_q),
        .lyr_write_en (lyr_write_en_bar1),
        .lyr_addr     (lyr_addr_bar1),
        .lyr_data_in  (lyr_data_in_bar1),
        .write_en     (write_en_bar1),
        .addr         (addr_bar1),
        .data_in      (data_in_bar1)
    );

endmodule

// File: tb/tb_mhsa_layer_scheduler.sv
// Bench for mhsa_layer_scheduler. Layer stubs answer each layer_start with
// a done after a per-layer delay (0 = never). Expected layer_start and done
// events are queued when a run is started and popped as the DUT emits them.
module tb_mhsa_layer_scheduler;
    import mhsa_pkg::*;

    localparam int WIDTH   = 64;
    localparam int N_LAYER = 4;
    localparam int TO      = 100;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [N_LAYER-1:0] layer_en;
    logic               busy;
    logic               done;
    logic               error;
    logic [1:0]         err_layer;
    logic [31:0]        cycle_cnt;
    logic [N_LAYER-1:0] layer_start;
    logic [N_LAYER-1:0] layer_done;
    logic [N_LAYER-1:0] stub_done;
    logic [N_LAYER-1:0] extra_done;
    logic               lyr_write_en_bar0 [N_LAYER];
    logic [MEM_AW-1:0]  lyr_addr_bar0     [N_LAYER];
    logic [WIDTH-1:0]   lyr_data_in_bar0  [N_LAYER];
    logic               lyr_write_en_bar1 [N_LAYER];
    logic [MEM_AW-1:0]  lyr_addr_bar1     [N_LAYER];
    logic [WIDTH-1:0]   lyr_data_in_bar1  [N_LAYER];
    logic               write_en_bar0;
    logic [MEM_AW-1:0]  addr_bar0;
    logic [WIDTH-1:0]   data_in_bar0;
    logic               write_en_bar1;
    logic [MEM_AW-1:0]  addr_bar1;
    logic [WIDTH-1:0]   data_in_bar1;
    logic [WIDTH-1:0]   data_out_bar0;
    logic [WIDTH-1:0]   data_out_bar1;

    assign layer_done = stub_done | extra_done;

    mhsa_layer_scheduler #(.WIDTH(WIDTH), .N_LAYER(N_LAYER), .TIMEOUT(32'd100)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .layer_en          (layer_en),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .err_layer         (err_layer),
        .cycle_cnt         (cycle_cnt),
        .layer_start       (layer_start),
        .layer_done        (layer_done),
        .lyr_write_en_bar0 (lyr_write_en_bar0),
        .lyr_addr_bar0     (lyr_addr_bar0),
        .lyr_data_in_bar0  (lyr_data_in_bar0),
        .lyr_write_en_bar1 (lyr_write_en_bar1),
        .lyr_addr_bar1     (lyr_addr_bar1),
        .lyr_data_in_bar1  (lyr_data_in_bar1),
        .write_en_bar0     (write_en_bar0),
        .addr_bar0         (addr_bar0),
        .data_in_bar0      (data_in_bar0),
        .write_en_bar1     (write_en_bar1),
        .addr_bar1         (addr_bar1),
        .data_in_bar1      (data_in_bar1),
        .data_out_bar0     (data_out_bar0),
        .data_out_bar1     (data_out_bar1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  done_q[$];
    int  delay [N_LAYER];
    int  rem   [N_LAYER];
    bit  dn    [N_LAYER];
    bit  kill;
    int  total = 0;
    int  bad   = 0;

    // Stub layers plus monitor, evaluated on every falling edge.
    task automatic bench_loop();
        int          run_idx;
        ev_t         ev;
        int          dcyc;
        logic        e_we0, e_we1;
        logic [31:0] e_a0, e_a1;
        logic [63:0] e_d0, e_d1;
        forever begin
            @(negedge clk);
            run_idx = -1;
            for (int i = 0; i < N_LAYER; i++) if (rem[i] > 0) run_idx = i;
            e_we0 = 1'b0; e_a0 = '0; e_d0 = '0;
            e_we1 = 1'b0; e_a1 = '0; e_d1 = '0;
            if (run_idx >= 0) begin
                e_we0 = lyr_write_en_bar0[run_idx];
                e_a0  = lyr_addr_bar0[run_idx];
                e_d0  = lyr_data_in_bar0[run_idx];
                e_we1 = lyr_write_en_bar1[run_idx];
                e_a1  = lyr_addr_bar1[run_idx];
                e_d1  = lyr_data_in_bar1[run_idx];
            end
            total++;
            if (write_en_bar0 !== e_we0 || addr_bar0 !== e_a0 || data_in_bar0 !== e_d0) begin
                bad++;
                $display("FAIL bar0 cyc=%0d got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                         cyc, write_en_bar0, addr_bar0, data_in_bar0, e_we0, e_a0, e_d0);
            end
            total++;
            if (write_en_bar1 !== e_we1 || addr_bar1 !== e_a1 || data_in_bar1 !== e_d1) begin
                bad++;
                $display("FAIL bar1 cyc=%0d got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                         cyc, write_en_bar1, addr_bar1, data_in_bar1, e_we1, e_a1, e_d1);
            end

            // Stub countdown: done is driven in the cycle the count expires.
            stub_done = '0;
            for (int i = 0; i < N_LAYER; i++) begin
                if (rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0 && dn[i]) stub_done[i] = 1'b1;
                end
            end

            if (layer_start !== '0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL layer_start_unexpected cyc=%0d got=%b want=none", cyc, layer_start);
                end else begin
                    ev = exp_q.pop_front();
                    if (layer_start !== (4'b0001 << ev.idx) || cyc != ev.cyc) begin
                        bad++;
                        $display("FAIL layer_start cyc=%0d got=%b want=%b at cyc=%0d",
                                 cyc, layer_start, 4'b0001 << ev.idx, ev.cyc);
                    end
                end
                for (int i = 0; i < N_LAYER; i++) begin
                    if (layer_start[i] === 1'b1) begin
                        rem[i] = (delay[i] == 0) ? TO : delay[i];
                        dn[i]  = (delay[i] != 0);
                    end
                end
            end

            if (done !== 1'b0) begin
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected cyc=%0d got=%b want=0", cyc, done);
                end else begin
                    dcyc = done_q.pop_front();
                    if (done !== 1'b1 || cyc != dcyc) begin
                        bad++;
                        $display("FAIL done_cycle got cyc=%0d val=%b want cyc=%0d", cyc, done, dcyc);
                    end
                end
            end

            if (kill) begin
                for (int i = 0; i < N_LAYER; i++) rem[i] = 0;
                kill = 1'b0;
            end
        end
    endtask

    // Queues the launch/done schedule of a full run; returns expected cycle_cnt.
    function automatic int plan_run(input logic [3:0] mask, input int t0);
        int l;
        l = t0 + 1;
        for (int i = 0; i < N_LAYER; i++) begin
            if (mask[i]) begin
                exp_q.push_back('{idx: i, cyc: l});
                l = l + delay[i] + 2;
            end
        end
        done_q.push_back(l);
        return l - t0;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) step();
    endtask

    task automatic pulse_start(input logic [3:0] mask, output int t0);
        layer_en = mask;
        start    = 1'b1;
        t0       = cyc;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        total++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got pending_starts=%0d pending_done=%0d want 0 0",
                     name, exp_q.size(), done_q.size());
            exp_q.delete();
            done_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || err_layer !== 2'd0 ||
            cycle_cnt !== 32'd0 || layer_start !== 4'd0) begin
            bad++;
            $display("FAIL reset_status got busy=%b done=%b err=%b el=%0d cnt=%0d ls=%b want all 0",
                     busy, done, error, err_layer, cycle_cnt, layer_start);
        end
        total++;
        if (write_en_bar0 !== 1'b0 || addr_bar0 !== 32'd0 || data_in_bar0 !== 64'd0 ||
            write_en_bar1 !== 1'b0 || addr_bar1 !== 32'd0 || data_in_bar1 !== 64'd0) begin
            bad++;
            $display("FAIL reset_bars got we0=%b a0=%h we1=%b a1=%h want 0", write_en_bar0, addr_bar0,
                     write_en_bar1, addr_bar1);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_run();
        int t0, exp_cnt;
        for (int i = 0; i < N_LAYER; i++) delay[i] = 40;
        pulse_start(4'b1111, t0);
        exp_cnt = plan_run(4'b1111, t0);
        wait_drain(400, "full_run");
        total++;
        if (busy !== 1'b0 || cycle_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL full_run_cnt got busy=%b cnt=%0d want busy=0 cnt=%0d", busy, cycle_cnt, exp_cnt);
        end
        step();
    endtask

    task automatic test_sparse_mask();
        int t0, t1, exp_cnt;
        delay[0] = 40; delay[1] = 20; delay[2] = 40; delay[3] = 15;
        pulse_start(4'b1010, t0);
        exp_cnt = plan_run(4'b1010, t0);
        goto_cycle(t0 + 6);
        pulse_start(4'b1111, t1);  // ignored while busy
        wait_drain(200, "sparse");
        total++;
        if (busy !== 1'b0 || cycle_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL sparse_cnt got busy=%b cnt=%0d want busy=0 cnt=%0d", busy, cycle_cnt, exp_cnt);
        end
        step();
    endtask

    task automatic test_empty_mask();
        int t0, exp_cnt;
        pulse_start(4'b0000, t0);
        exp_cnt = plan_run(4'b0000, t0);
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || layer_start !== 4'd0) begin
            bad++;
            $display("FAIL empty_done got done=%b busy=%b ls=%b want 1 1 0000", done, busy, layer_start);
        end
        wait_drain(10, "empty");
        total++;
        if (busy !== 1'b0 || cycle_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL empty_cnt got busy=%b cnt=%0d want busy=0 cnt=%0d", busy, cycle_cnt, exp_cnt);
        end
        step();
    endtask

    task automatic test_abort();
        int t0, l1;
        delay[0] = 10; delay[1] = 30; delay[2] = 10; delay[3] = 10;
        pulse_start(4'b1111, t0);
        l1 = t0 + 1 + delay[0] + 2;
        exp_q.push_back('{idx: 0, cyc: t0 + 1});
        exp_q.push_back('{idx: 1, cyc: l1});
        goto_cycle(l1 + 5);
        extra_done = 4'b0001;      // spurious done from a non-selected layer
        step();
        extra_done = 4'b0000;
        goto_cycle(l1 + delay[1]); // cycle in which layer 1 reports done
        abort = 1'b1;
        kill  = 1'b1;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_pre got busy=%b done=%b want 1 0", busy, done);
        end
        step();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || layer_start !== 4'd0) begin
            bad++;
            $display("FAIL abort_idle got busy=%b done=%b ls=%b want 0 0 0000", busy, done, layer_start);
        end
        repeat (5) step();
        wait_drain(1, "abort");
    endtask

    task automatic test_timeout();
        int t0, t1, l2;
        delay[0] = 5; delay[1] = 5; delay[2] = 0; delay[3] = 5;
        pulse_start(4'b1111, t0);
        l2 = t0 + 1 + 7 + 7;
        exp_q.push_back('{idx: 0, cyc: t0 + 1});
        exp_q.push_back('{idx: 1, cyc: t0 + 8});
        exp_q.push_back('{idx: 2, cyc: l2});
        goto_cycle(l2 + TO);       // last RUN cycle before the watchdog fires
        total++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_edge got err=%b busy=%b want 0 1", error, busy);
        end
        step();
        total++;
        if (error !== 1'b1 || err_layer !== 2'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_err got err=%b el=%0d busy=%b want 1 2 1", error, err_layer, busy);
        end
        pulse_start(4'b1111, t1);  // ignored in ERR
        repeat (5) step();
        total++;
        if (busy !== 1'b1 || error !== 1'b1) begin
            bad++;
            $display("FAIL err_hold got busy=%b err=%b want 1 1", busy, error);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || error !== 1'b1 || err_layer !== 2'd2) begin
            bad++;
            $display("FAIL err_abort got busy=%b err=%b el=%0d want 0 1 2", busy, error, err_layer);
        end
        wait_drain(1, "timeout");
        step();
    endtask

    task automatic test_reset_midrun();
        int t0, l1;
        for (int i = 0; i < N_LAYER; i++) delay[i] = 30;
        pulse_start(4'b1111, t0);
        exp_cnt_dummy(t0);
        l1 = t0 + 1 + 32;
        goto_cycle(l1 + 10);
        rst  = 1'b1;
        kill = 1'b1;
        exp_q.delete();
        done_q.delete();
        step();
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || err_layer !== 2'd0 ||
            cycle_cnt !== 32'd0 || layer_start !== 4'd0 || write_en_bar0 !== 1'b0 ||
            addr_bar0 !== 32'd0 || write_en_bar1 !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got busy=%b done=%b err=%b el=%0d cnt=%0d ls=%b we0=%b want all 0",
                     busy, done, error, err_layer, cycle_cnt, layer_start, write_en_bar0);
        end
        step();
    endtask

    // Expectations up to the point where reset cuts the run short.
    task automatic exp_cnt_dummy(input int t0);
        exp_q.push_back('{idx: 0, cyc: t0 + 1});
        exp_q.push_back('{idx: 1, cyc: t0 + 33});
    endtask

    task automatic test_back_to_back();
        int t0, exp_cnt;
        for (int i = 0; i < N_LAYER; i++) delay[i] = 3;
        pulse_start(4'b0110, t0);
        exp_cnt = plan_run(4'b0110, t0);
        wait_drain(50, "b2b_a");
        total++;
        if (cycle_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL b2b_a_cnt got=%0d want=%0d", cycle_cnt, exp_cnt);
        end
        pulse_start(4'b1001, t0);
        exp_cnt = plan_run(4'b1001, t0);
        wait_drain(50, "b2b_b");
        total++;
        if (busy !== 1'b0 || cycle_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL b2b_b_cnt got busy=%b cnt=%0d want busy=0 cnt=%0d", busy, cycle_cnt, exp_cnt);
        end
    endtask

    initial begin
        start      = 1'b0;
        abort      = 1'b0;
        layer_en   = '0;
        stub_done  = '0;
        extra_done = '0;
        kill       = 1'b0;
        data_out_bar0 = 64'h0;
        data_out_bar1 = 64'h0;
        for (int i = 0; i < N_LAYER; i++) begin
            delay[i] = 0;
            rem[i]   = 0;
            dn[i]    = 1'b0;
            lyr_write_en_bar0[i] = 1'b1;
            lyr_addr_bar0[i]     = 32'h1000 + 32'(i * 16);
            lyr_data_in_bar0[i]  = {32'hA0A0_0000 + 32'(i), 32'h0000_5A5A};
            lyr_write_en_bar1[i] = (i % 2) == 1;
            lyr_addr_bar1[i]     = 32'h2000 + 32'(i);
            lyr_data_in_bar1[i]  = {32'(i), 32'hFFFF_0000};
        end
        test_reset();
        fork
            bench_loop();
        join_none
        test_full_run();
        test_sparse_mask();
        test_empty_mask();
        test_abort();
        test_timeout();
        test_reset_midrun();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
